// File: rtl/clock_set_ctrl.sv
// Time-of-day sequencing controller: 1 Hz prescaler, hh/mm/ss edit mode FSM,
// commit-as-parallel-load to the BCD counter chain, and display/blink steering.
module clock_set_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       tick_en,
    output logic       load,
    output logic [7:0] load_hour,
    output logic [7:0] load_min,
    output logic [7:0] load_sec,
    output logic [1:0] edit_sel,
    output logic       blink,
    output logic [7:0] disp_hour,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] presCnt_q, presCnt_d;
    logic [BW-1:0] blinkCnt_q;
    logic          blink_q, load_q;
    logic [1:0]    editSel_q;
    logic [7:0]    editHour_q, editMin_q, editSec_q;
    logic [7:0]    editHour_d, editMin_d, editSec_d;
    logic          inSet_q, inSet_d, enterSet;

    // One BCD step with wrap at maxTens:maxUnits; anything not a legal value restarts at 00.
    function automatic logic [7:0] bcdStep(input logic [7:0] v, input logic up,
                                           input logic [3:0] maxTens, input logic [3:0] maxUnits);
        logic       valid;
        logic [7:0] res;
        valid = (v[3:0] <= 4'd9) &&
                ((v[7:4] < maxTens) || ((v[7:4] == maxTens) && (v[3:0] <= maxUnits)));
        if (!valid)
            res = 8'h00;
        else if (up) begin
            if (v == {maxTens, maxUnits})
                res = 8'h00;
            else if (v[3:0] == 4'd9)
                res = {4'(v[7:4] + 4'd1), 4'd0};
            else
                res = {v[7:4], 4'(v[3:0] + 4'd1)};
        end else begin
            if (v == 8'h00)
                res = {maxTens, maxUnits};
            else if (v[3:0] == 4'd0)
                res = {4'(v[7:4] - 4'd1), 4'd9};
            else
                res = {v[7:4], 4'(v[3:0] - 4'd1)};
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (btn_mode) state_d = SET_H;
            SET_H:   if (btn_mode) state_d = SET_M;
            SET_M:   if (btn_mode) state_d = SET_S;
            SET_S:   if (btn_mode) state_d = COMMIT;
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign inSet_q  = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);
    assign inSet_d  = (state_d == SET_H) || (state_d == SET_M) || (state_d == SET_S);
    assign enterSet = inSet_d && (state_d != state_q);

    // Mode advance takes priority over inc/dec; inc and dec together cancel.
    always_comb begin
        editHour_d = editHour_q;
        editMin_d  = editMin_q;
        editSec_d  = editSec_q;
        if (state_q == RUN && btn_mode) begin
            editHour_d = cur_hour;
            editMin_d  = cur_min;
            editSec_d  = cur_sec;
        end else if (inSet_q && !btn_mode && (btn_inc ^ btn_dec)) begin
            case (state_q)
                SET_H:   editHour_d = bcdStep(editHour_q, btn_inc, 4'd2, 4'd3);
                SET_M:   editMin_d  = bcdStep(editMin_q,  btn_inc, 4'd5, 4'd9);
                SET_S:   editSec_d  = bcdStep(editSec_q,  btn_inc, 4'd5, 4'd9);
                default: ;
            endcase
        end
    end

    always_comb begin
        presCnt_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            if (!run_en)
                presCnt_d = presCnt_q;
            else if (presCnt_q != TICK_LAST)
                presCnt_d = presCnt_q + TW'(1);
        end
    end

    // Outputs tied to the mode are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            presCnt_q  <= '0;
            blinkCnt_q <= '0;
            blink_q    <= 1'b0;
            load_q     <= 1'b0;
            editSel_q  <= 2'd0;
            editHour_q <= 8'h00;
            editMin_q  <= 8'h00;
            editSec_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            presCnt_q  <= presCnt_d;
            editHour_q <= editHour_d;
            editMin_q  <= editMin_d;
            editSec_q  <= editSec_d;
            load_q     <= (state_d == COMMIT);
            case (state_d)
                SET_H:   editSel_q <= 2'd1;
                SET_M:   editSel_q <= 2'd2;
                SET_S:   editSel_q <= 2'd3;
                default: editSel_q <= 2'd0;
            endcase
            if (enterSet) begin
                blink_q    <= 1'b1;
                blinkCnt_q <= '0;
            end else if (inSet_d) begin
                if (blinkCnt_q == BLINK_LAST) begin
                    blinkCnt_q <= '0;
                    blink_q    <= ~blink_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + BW'(1);
                end
            end else begin
                blink_q    <= 1'b0;
                blinkCnt_q <= '0;
            end
        end
    end

    assign tick_en   = (state_q == RUN) && run_en && (presCnt_q == TICK_LAST);
    assign load      = load_q;
    assign edit_sel  = editSel_q;
    assign blink     = blink_q;
    assign load_hour = editHour_q;
    assign load_min  = editMin_q;
    assign load_sec  = editSec_q;
    assign disp_hour = inSet_q ? editHour_q : cur_hour;
    assign disp_min  = inSet_q ? editMin_q  : cur_min;
    assign disp_sec  = inSet_q ? editSec_q  : cur_sec;

endmodule
